// File: rtl/cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_pkg : occupancy encoding and buffer depth for cmd_dispatch       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cmd_pkg;

  localparam int CMD_BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage : cmd_pkg
`default_nettype wire

// File: rtl/cmd_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_skid_buf : 2-entry ordered head/skid buffer with occupancy FSM   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmd_skid_buf
  import cmd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output occ_e             occ_o,
  output logic [WIDTH-1:0] head_o
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (capture_i) begin
          head_d = data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({capture_i, pop_i})
          2'b10: begin
            skid_d = data_i;
            occ_d  = OCC_TWO;
          end
          2'b01:   occ_d  = OCC_EMPTY;
          2'b11:   head_d = data_i;
          default: occ_d  = OCC_ONE;
        endcase
      end
      OCC_TWO: begin
        // Capture while full is excluded by the upstream credit check.
        if (pop_i) begin
          head_d = skid_q;
          if (capture_i) begin
            skid_d = data_i;
          end else begin
            occ_d = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule : cmd_skid_buf
`default_nettype wire

// File: rtl/cmd_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_dispatch : drains a 1-cycle-latency command FIFO into a          |
// | valid/ready stream. Optional StatCnt under CMD_DISPATCH_STAT_EN.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             FifoEmpty,
  output logic             FifoRdEn,
  input  logic [WIDTH-1:0] FifoQ,
  output logic             CmdValid,
  input  logic             CmdReady,
  output logic [WIDTH-1:0] CmdData,
`ifdef CMD_DISPATCH_STAT_EN
  output logic [15:0]      StatCnt,
`endif
  output logic             Busy
);

  occ_e       w_occ;
  logic       inflight_q, inflight_d;
  logic       w_fire;
  logic [2:0] w_pending;

  assign CmdValid  = (w_occ != OCC_EMPTY);
  assign w_fire    = CmdValid && CmdReady;
  // Slots committed after this edge; fire only occurs with occupancy >= 1.
  assign w_pending = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_fire};
  assign FifoRdEn  = !Reset && !FifoEmpty && (w_pending < 3'(CMD_BUF_DEPTH));
  assign inflight_d = FifoRdEn;
  assign Busy      = CmdValid || inflight_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  cmd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (Clk),
    .rst       (Reset),
    .capture_i (inflight_q),
    .pop_i     (w_fire),
    .data_i    (FifoQ),
    .occ_o     (w_occ),
    .head_o    (CmdData)
  );

`ifdef CMD_DISPATCH_STAT_EN
  logic [15:0] stat_q, stat_d;

  assign stat_d = w_fire ? stat_q + 16'd1 : stat_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign StatCnt = stat_q;
`endif

endmodule : cmd_dispatch
`default_nettype wire
